// File: rtl/clock_pkg.sv
// Shared types, limits and display helpers for the alarm clock.
// Hours are kept internally as 0..23 and converted only for display.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HR24_MAX = 5'd23;
  localparam logic [4:0] HALF_DAY = 5'd12;

  function automatic logic [5:0] to_12h(input logic [4:0] h24);
    logic [4:0] h;
    if (h24 == 5'd0)
      h = HALF_DAY;
    else if (h24 > HALF_DAY)
      h = h24 - HALF_DAY;
    else
      h = h24;
    return {h, (h24 >= HALF_DAY)};
  endfunction

  function automatic logic [4:0] flip_half(input logic [4:0] h24);
    return (h24 < HALF_DAY) ? h24 + HALF_DAY : h24 - HALF_DAY;
  endfunction

  function automatic logic [4:0] inc_hr(input logic [4:0] h24);
    return (h24 == HR24_MAX) ? 5'd0 : h24 + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == MIN_MAX) ? 6'd0 : m + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_clock_btn_edge.sv
// Rising-edge detector for a level button.
// One pulse per press, however long the button is held.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // history register; cleared so a held button fires once after reset
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/alarm_clock.sv
// Time-of-day clock with 12h/24h display and a snoozable alarm.
// Prescaler, time/alarm registers and the alarm FSM live here.
module alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC    = 50_000_000,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_min,
  input  logic       set_hr,
  input  logic       set_ampm,
  input  logic       alarm_sel,
  input  logic       alarm_en,
  input  logic       mode24,
  input  logic       snooze,
  input  logic       ack,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic       ampm,
  output logic       ring,
  output logic [1:0] alarm_state
);

  localparam int PW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW   = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int SNZ  = SNOOZE_MIN * 60;
  localparam int SW   = $clog2(SNZ + 1);

  logic e_min, e_hr, e_ampm, e_snz, e_ack;

  btn_edge u_e_min  (.clk(clk), .rst(rst), .in(set_min),  .pulse(e_min));
  btn_edge u_e_hr   (.clk(clk), .rst(rst), .in(set_hr),   .pulse(e_hr));
  btn_edge u_e_ampm (.clk(clk), .rst(rst), .in(set_ampm), .pulse(e_ampm));
  btn_edge u_e_snz  (.clk(clk), .rst(rst), .in(snooze),   .pulse(e_snz));
  btn_edge u_e_ack  (.clk(clk), .rst(rst), .in(ack),      .pulse(e_ack));

  logic [PW-1:0] presc, presc_n;
  logic [5:0]    sec_n, min_n, al_min, al_min_n;
  logic [4:0]    h24, h24_n, al_h24, al_h24_n;
  logic          tick, t_set, step, match;

  alarm_state_t  state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [SW-1:0] scnt, scnt_n;

  // next time/alarm values: set edges win over the coincident tick
  always_comb begin
    tick     = (presc == PW'(TICKS_PER_SEC - 1));
    t_set    = ~alarm_sel & (e_min | e_hr | e_ampm);
    step     = tick & ~t_set;
    presc_n  = tick ? '0 : presc + PW'(1);
    sec_n    = sec;
    min_n    = min;
    h24_n    = h24;
    al_min_n = al_min;
    al_h24_n = al_h24;
    if (t_set) begin
      presc_n = '0;
      sec_n   = '0;
      if (e_min)  min_n = inc_min(min);
      if (e_hr)   h24_n = inc_hr(h24);
      if (e_ampm) h24_n = flip_half(h24_n);
    end else if (tick) begin
      if (sec == SEC_MAX) begin
        sec_n = '0;
        min_n = inc_min(min);
        if (min == MIN_MAX) h24_n = inc_hr(h24);
      end else begin
        sec_n = sec + 6'd1;
      end
    end
    if (alarm_sel) begin
      if (e_min)  al_min_n = inc_min(al_min);
      if (e_hr)   al_h24_n = inc_hr(al_h24);
      if (e_ampm) al_h24_n = flip_half(al_h24_n);
    end
    match = step & alarm_en & (sec_n == 6'd0) &
            (min_n == al_min) & (h24_n == al_h24);
  end

  // alarm FSM next state: ack > disable > snooze > timeout
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    scnt_n  = scnt;
    unique case (state)
      IDLE: begin
        if (match) begin
          state_n = RINGING;
          rcnt_n  = '0;
        end
      end
      RINGING: begin
        if (e_ack | ~alarm_en) begin
          state_n = IDLE;
        end else if (e_snz) begin
          state_n = SNOOZE;
          scnt_n  = SW'(SNZ);
        end else if (step) begin
          if (rcnt == RW'(RING_TIMEOUT_SEC - 1)) state_n = IDLE;
          else                                    rcnt_n  = rcnt + RW'(1);
        end
      end
      SNOOZE: begin
        if (e_ack | ~alarm_en) begin
          state_n = IDLE;
        end else if (step) begin
          if (scnt == SW'(1)) begin
            state_n = RINGING;
            rcnt_n  = '0;
          end
          scnt_n = scnt - SW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // register update
  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      sec    <= '0;
      min    <= '0;
      h24    <= '0;
      al_min <= '0;
      al_h24 <= '0;
      state  <= IDLE;
      rcnt   <= '0;
      scnt   <= '0;
      ring   <= 1'b0;
    end else begin
      presc  <= presc_n;
      sec    <= sec_n;
      min    <= min_n;
      h24    <= h24_n;
      al_min <= al_min_n;
      al_h24 <= al_h24_n;
      state  <= state_n;
      rcnt   <= rcnt_n;
      scnt   <= scnt_n;
      ring   <= (state_n == RINGING);
    end
  end

  // display conversion, follows mode24 in the same cycle
  always_comb begin
    {hr, ampm} = to_12h(h24);
    if (mode24) begin
      hr   = h24;
      ampm = 1'b0;
    end
  end

  assign alarm_state = state;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock (4 ticks/s, 1 min snooze).
// Expectations are queued by the stimulus and drained by a monitor.
module tb_alarm_clock;

  logic       clk = 1'b0;
  logic       rst, set_min, set_hr, set_ampm;
  logic       alarm_sel, alarm_en, mode24, snooze, ack;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       ampm, ring;
  logic [1:0] alarm_state;

  alarm_clock #(
    .TICKS_PER_SEC(4),
    .SNOOZE_MIN(1),
    .RING_TIMEOUT_SEC(60)
  ) dut (
    .clk(clk), .rst(rst),
    .set_min(set_min), .set_hr(set_hr), .set_ampm(set_ampm),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .mode24(mode24),
    .snooze(snooze), .ack(ack),
    .sec(sec), .min(min), .hr(hr), .ampm(ampm),
    .ring(ring), .alarm_state(alarm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // monitor: compare every queued expectation against live outputs
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [20:0] a;
      e = sb.pop_front();
      a = {sec, min, hr, ampm, ring, alarm_state};
      checks++;
      if (a !== e.v) begin
        failures++;
        $display("FAIL %s: got s=%0d m=%0d h=%0d pm=%0d ring=%0d st=%0d want s=%0d m=%0d h=%0d pm=%0d ring=%0d st=%0d",
                 e.name, a[20:15], a[14:9], a[8:4], a[3], a[2], a[1:0],
                 e.v[20:15], e.v[14:9], e.v[8:4], e.v[3], e.v[2], e.v[1:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int h, input int m,
                     input int s, input int pm, input int rg,
                     input int st);
    exp_t e;
    e.name = nm;
    e.v = {6'(s), 6'(m), 5'(h), 1'(pm), 1'(rg), 2'(st)};
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: set_min = 1'b1;
      1: set_hr = 1'b1;
      default: set_ampm = 1'b1;
    endcase
    step(1);
    set_min  = 1'b0;
    set_hr   = 1'b0;
    set_ampm = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; set_min = 0; set_hr = 0; set_ampm = 0;
    alarm_sel = 0; alarm_en = 0; mode24 = 0; snooze = 0; ack = 0;
    step(1);
    rst = 1'b0;
    chk("reset_12h", 12, 0, 0, 0, 0, 0);
    mode24 = 1'b1;
    step(1);
    chk("reset_24h", 0, 0, 0, 0, 0, 0);
    step(3);
    chk("first_sec", 0, 0, 1, 0, 0, 0);
    mode24 = 1'b0;

    repeat (23) press(1);
    repeat (59) press(0);
    step(235);
    chk("pre_roll", 11, 59, 59, 1, 0, 0);
    step(4);
    chk("rollover", 12, 0, 0, 0, 0, 0);

    set_min = 1'b1;
    step(1);
    chk("hold_edge", 12, 1, 0, 0, 0, 0);
    step(9);
    chk("hold_long", 12, 1, 2, 0, 0, 0);
    set_min = 1'b0;
    repeat (3) press(1);
    set_ampm = 1'b1;
    step(1);
    chk("ampm_3pm", 3, 1, 0, 1, 0, 0);
    set_ampm = 1'b0;
    step(3);
    set_min = 1'b1;
    step(1);
    chk("set_vs_tick", 3, 2, 0, 1, 0, 0);
    set_min = 1'b0;

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    alarm_sel = 1'b1;
    press(0);
    press(0);
    alarm_sel = 1'b0;
    alarm_en = 1'b1;
    step(475);
    chk("pre_alarm", 12, 1, 59, 0, 0, 0);
    step(1);
    chk("alarm_ring", 12, 2, 0, 0, 1, 1);
    ack = 1'b1;
    step(1);
    chk("ack_idle", 12, 2, 0, 0, 0, 0);
    ack = 1'b0;

    alarm_sel = 1'b1;
    press(0);
    alarm_sel = 1'b0;
    step(237);
    chk("ring_0003", 12, 3, 0, 0, 1, 1);
    snooze = 1'b1;
    step(1);
    chk("snooze_in", 12, 3, 0, 0, 0, 2);
    snooze = 1'b0;
    step(238);
    chk("snooze_end", 12, 3, 59, 0, 0, 2);
    step(1);
    chk("re_ring", 12, 4, 0, 0, 1, 1);
    alarm_en = 1'b0;
    step(1);
    chk("disarm", 12, 4, 0, 0, 0, 0);
    alarm_en = 1'b1;

    alarm_sel = 1'b1;
    press(0);
    press(0);
    alarm_sel = 1'b0;
    step(235);
    chk("ring_0005", 12, 5, 0, 0, 1, 1);
    step(239);
    chk("pre_timeout", 12, 5, 59, 0, 1, 1);
    step(1);
    chk("timeout", 12, 6, 0, 0, 0, 0);

    alarm_sel = 1'b1;
    press(0);
    press(0);
    alarm_sel = 1'b0;
    step(236);
    chk("ring_0007", 12, 7, 0, 0, 1, 1);
    snooze = 1'b1;
    step(1);
    chk("snooze2", 12, 7, 0, 0, 0, 2);
    snooze = 1'b0;
    step(10);
    chk("snooze2_run", 12, 7, 2, 0, 0, 2);
    rst = 1'b1;
    step(1);
    chk("rst_snooze", 12, 0, 0, 0, 0, 0);
    rst = 1'b0;

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
